// File: rtl/el2_pkg.sv
// Shared types and constants for the EL2 execution-unit divider.
package el2_pkg;

    typedef struct packed {
        logic valid;
        logic unsign;
        logic rem;
    } el2_div_pkt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } el2_div_state_t;

    localparam int DIV_ITERATIONS = 32;

endpackage

// File: rtl/el2_exu_div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference if it fits.
module el2_exu_div_step (
    input  logic [33:0] rem_in,
    input  logic [31:0] quo_in,
    input  logic [31:0] divisor,
    output logic [33:0] rem_out,
    output logic [31:0] quo_out
);

    logic [34:0] shifted;
    logic [34:0] diff;

    // NOTE: combinational logic uses blocking assignments and drives every output on every path, so no latch is inferred.
    always_comb begin
        shifted = {rem_in, quo_in[31]};
        diff    = shifted - {3'b000, divisor};
        rem_out = diff[34] ? shifted[33:0] : diff[33:0];
        quo_out = {quo_in[30:0], ~diff[34]};
    end

endmodule

// File: rtl/el2_exu_div_seq.sv
// Sequential 32-bit integer divider: 32 restoring steps on magnitudes, one
// sign-fix cycle, and single-cycle answers for divide-by-zero and overflow.
module el2_exu_div_seq
    import el2_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  el2_div_pkt_t dp,
    input  logic [31:0]  dividend,
    input  logic [31:0]  divisor,
    input  logic         cancel,
    output logic         busy,
    output logic         finish,
    output logic [31:0]  result
);

    el2_div_state_t state;
    logic [4:0]     cnt;
    logic [31:0]    quo;
    logic [33:0]    part_rem;
    logic [31:0]    dvsr;
    logic           unsign_q;
    logic           rem_q;
    logic           sign_a;
    logic           sign_b;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div_zero;
    logic        sgn_ovf;
    logic [31:0] special_res;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [33:0] step_rem;
    logic [31:0] step_quo;

    always_comb begin
        mag_a    = (!dp.unsign && dividend[31]) ? (~dividend + 32'd1) : dividend;
        mag_b    = (!dp.unsign && divisor[31])  ? (~divisor + 32'd1)  : divisor;
        div_zero = (divisor == 32'd0);
        sgn_ovf  = !dp.unsign && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

        if (div_zero)
            special_res = dp.rem ? dividend : 32'hFFFF_FFFF;
        else
            special_res = dp.rem ? 32'd0 : 32'h8000_0000;

        // Negating a zero remainder yields zero, so no separate zero test is needed.
        q_fix = (!unsign_q && (sign_a ^ sign_b)) ? (~quo + 32'd1) : quo;
        r_fix = (!unsign_q && sign_a) ? (~part_rem[31:0] + 32'd1) : part_rem[31:0];
    end

    el2_exu_div_step u_step (
        .rem_in  (part_rem),
        .quo_in  (quo),
        .divisor (dvsr),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            quo      <= 32'd0;
            part_rem <= 34'd0;
            dvsr     <= 32'd0;
            unsign_q <= 1'b0;
            rem_q    <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            busy     <= 1'b0;
            finish   <= 1'b0;
            result   <= 32'd0;
        end else begin
            finish <= 1'b0;
            result <= 32'd0;
            case (state)
                IDLE: begin
                    if (dp.valid && !cancel) begin
                        unsign_q <= dp.unsign;
                        rem_q    <= dp.rem;
                        sign_a   <= dividend[31];
                        sign_b   <= divisor[31];
                        quo      <= mag_a;
                        part_rem <= 34'd0;
                        dvsr     <= mag_b;
                        cnt      <= 5'd0;
                        busy     <= 1'b1;
                        if (div_zero || sgn_ovf) begin
                            state  <= DONE;
                            finish <= 1'b1;
                            result <= special_res;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= 5'd0;
                    end else begin
                        quo      <= step_quo;
                        part_rem <= step_rem;
                        cnt      <= cnt + 5'd1;
                        if (cnt == 5'(DIV_ITERATIONS - 1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state  <= DONE;
                        finish <= 1'b1;
                        result <= rem_q ? r_fix : q_fix;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
